// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
// FSM encoding, default width and lookahead group size.
package div16_seq_pkg;

    localparam int DIV_W = 16;
    localparam int GRP   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div16_seq_sub_bla.sv
// N-bit subtractor a - b with 4-bit group borrow-lookahead.
// Operands are zero-padded up to a whole number of groups.
module sub_bla
    import div16_seq_pkg::*;
#(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int NG = (N + GRP - 1) / GRP;
    localparam int WP = NG * GRP;

    logic [WP-1:0] ap;
    logic [WP-1:0] bp;
    logic [WP-1:0] g;
    logic [WP-1:0] p;
    logic [WP-1:0] bin;
    logic [WP-1:0] dp;
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [NG:0]   cg;
    logic [WP-1:0] unused_pad;

    always_comb begin
        ap  = WP'(a);
        bp  = WP'(b);
        // a bit borrows when a<b, passes an incoming borrow when a==b
        g   = ~ap & bp;
        p   = ~(ap ^ bp);
        gg  = '0;
        pg  = '0;
        cg  = '0;
        bin = '0;
        for (int k = 0; k < NG; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
        for (int k = 0; k < NG; k++) begin
            cg[k+1] = gg[k] | (pg[k] & cg[k]);
        end
        for (int k = 0; k < NG; k++) begin
            bin[4*k]   = cg[k];
            bin[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            bin[4*k+2] = g[4*k+1]
                       | (p[4*k+1] & g[4*k])
                       | (p[4*k+1] & p[4*k] & cg[k]);
            bin[4*k+3] = g[4*k+2]
                       | (p[4*k+2] & g[4*k+1])
                       | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
        dp = ap ^ bp ^ bin;
    end

    assign diff       = dp[N-1:0];
    assign borrow     = cg[NG];
    assign unused_pad = dp;

endmodule

// File: rtl/div16_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
// Divide by zero short-circuits straight to DONE.
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int          CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W:0]    r_q, r_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    t;
    logic [W:0]    diff;
    logic          borrow;
    logic          unused_r_msb;

    assign t            = {r_q[W-1:0], q_q[W-1]};
    assign unused_r_msb = r_q[W];

    sub_bla #(
        .N (W + 1)
    ) u_sub (
        .a      (t),
        .b      ({1'b0, d_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    r_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = '0;
                    dbz_d = (divisor == '0);
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (borrow) begin
                    r_d = t;
                    q_d = {q_q[W-2:0], 1'b0};
                end else begin
                    r_d = diff;
                    q_d = {q_q[W-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                // results land in the output registers as DONE is entered
                if (cnt_q == LAST) begin
                    quo_d   = q_d;
                    rem_d   = r_d[W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Scoreboard bench for div16_seq: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_div16_seq;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    div16_seq #(
        .W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: q=0x%0h r=0x%0h",
                         quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", {16'd0, quotient}, {16'd0, e.q});
                check("remainder", {16'd0, remainder}, {16'd0, e.r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            end
        end
    end

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic ez, input int exp_lat);
        int   lat;
        int   bcnt;
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.q = eq;
        e.r = er;
        e.z = ez;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        wait_done(lat, bcnt);
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        @(posedge clk);
        #1;
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        check("quotient_held", {16'd0, quotient}, {16'd0, eq});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bcnt;
        int          saved;
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {busy, done, div_by_zero, quotient, remainder}, 32'd0);
        rst = 1'b0;

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        run_op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);
        run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
        run_op(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
        run_op(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 17);
        run_op(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1);
        run_op(16'h8000, 16'h0003, 16'd10922, 16'd2, 1'b0, 17);
        run_op(16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0, 17);

        // start held high across a whole operation with changing operands
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd200;
        divisor  = 16'd7;
        e = '{q: 16'd28, r: 16'd4, z: 1'b0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        wait_done(lat, bcnt);
        check("held_start_latency", lat, 17);
        e = '{q: 16'd333, r: 16'd1, z: 1'b0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        check("held_start_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'h5555;
        divisor  = 16'h0000;
        wait_done(lat, bcnt);
        check("second_start_latency", lat, 17);
        @(posedge clk);
        #1;

        // reset during RUN aborts without a done pulse
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        saved = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_run_outputs",
              {busy, done, div_by_zero, quotient, remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_rst", done_cnt, saved);
        run_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17);

        // model-checked sweep
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            if (i % 4 == 0) b = 16'($urandom_range(0, 15));
            else            b = 16'($urandom);
            if (b == 16'd0) run_op(a, b, 16'hFFFF, a, 1'b1, 1);
            else            run_op(a, b, a / b, a % b, 1'b0, 17);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
